draw_sequencer: RTL

Command scheduler for the drawing engines. It queues draw opcodes from the host and issues them one at a time to the circle-fill, circle-draw, rectangle-fill, rectangle-draw, line-draw and frame-update engines. It drives the shared coordinate mux select so that only the active engine's coordinates reach the framebuffer, and it keeps the select stable until the registered mux has sampled the engine's final output.

---
 rtl/draw_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/draw_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : draw_sequencer                                               |
// | Description : Command scheduler for the drawing engines. Queues 4-bit      |
// |               draw opcodes from the host and issues them one at a time to  |
// |               CF/CD/RF/RD/LD/FU engines. It holds the shared coordinate    |
// |               mux select (SEL) until the registered mux has sampled the    |
// |               engine's final output. Frame-update requests take priority   |
// |               over queued commands.                                        |
// | Ports       : CLK, RST_N (sync, active low)                                |
// |               cmd_valid/cmd_op/cmd_ready : host command queue push side    |
// |               fu_req    : frame-update request level                       |
// |               eng_done  : per-engine done pulses {FU,LD,RD,RF,CD,CF}       |
// |               start     : one-cycle engine start pulse, same mapping       |
// |               SEL       : mux select, opcode encoding, 15 = idle           |
// |               busy, err : activity and sticky error flags                  |
// | Options     : DRAW_SEQ_TIMEOUT_EN - WAIT watchdog of TIMEOUT_CYCLES        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module draw_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_op,
  output logic       cmd_ready,
  input  logic       fu_req,
  input  logic [5:0] eng_done,
  output logic [5:0] start,
  output logic [3:0] SEL,
  output logic       busy,
  output logic       err
);

  localparam int           c_aw       = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_full    = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [3:0]   c_op_fu    = 4'd10;
  localparam logic [3:0]   c_op_nop   = 4'd15;
  localparam logic [3:0]   c_sel_idle = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Degenerate configurations are rejected at elaboration.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("draw_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  // Opcode to engine one-hot; illegal opcodes and NOP map to zero.
  function automatic logic [5:0] f_onehot(input logic [3:0] op);
    logic [5:0] v;
    v = 6'b000000;
    case (op)
      4'd0:    v = 6'b000001;
      4'd1:    v = 6'b000010;
      4'd2:    v = 6'b000100;
      4'd3:    v = 6'b001000;
      4'd4:    v = 6'b010000;
      c_op_fu: v = 6'b100000;
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

  // ---------------- command queue ----------------
  logic [3:0]      r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_push;
  logic            w_pop;
  logic [3:0]      w_head;

  assign cmd_ready = (r_count != c_full);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cmd_op;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- sequencer FSM ----------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_op;
  logic [3:0] w_op_nxt;
  logic [5:0] r_start;
  logic [5:0] w_start_nxt;
  logic [3:0] r_sel;
  logic [3:0] w_sel_nxt;
  logic       r_err;
  logic       w_err_set;
  logic       w_done_hit;
  logic       w_timeout;

  // Only the active engine's done bit counts; r_op is NOP (no bits) in IDLE.
  assign w_done_hit = |(eng_done & f_onehot(r_op));

`ifdef DRAW_SEQ_TIMEOUT_EN
  localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_tw-1:0] r_wd_cnt;

  // Counts WAIT cycles; expiry fires in the TIMEOUT_CYCLES-th WAIT cycle so
  // the counter reaches TIMEOUT_CYCLES on the same edge that enters DRAIN.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && (r_wd_cnt == c_tw'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fu_req) begin
          // Frame update wins over the queue and leaves it untouched.
          w_state_nxt = ST_ISSUE;
          w_op_nxt    = c_op_fu;
        end else if (r_count != '0) begin
          w_pop = 1'b1;
          if (|f_onehot(w_head)) begin
            w_state_nxt = ST_ISSUE;
            w_op_nxt    = w_head;
          end else if (w_head != c_op_nop) begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_done_hit) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_timeout) begin
          w_state_nxt = ST_DRAIN;
          w_err_set   = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_IDLE;
        w_op_nxt    = c_op_nop;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_op_nxt    = c_op_nop;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    w_start_nxt = (w_state_nxt == ST_ISSUE) ? f_onehot(w_op_nxt) : 6'b000000;
    w_sel_nxt   = (w_state_nxt == ST_IDLE)  ? c_sel_idle : w_op_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_op    <= c_op_nop;
      r_start <= 6'b000000;
      r_sel   <= c_sel_idle;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_start <= w_start_nxt;
      r_sel   <= w_sel_nxt;
      r_err   <= r_err | w_err_set;
    end
  end

  assign start = r_start;
  assign SEL   = r_sel;
  assign err   = r_err;
  assign busy  = (r_state != ST_IDLE) || (r_count != '0);

endmodule
`default_nettype wire
